ysyx_23060124__axi_rd_arb: RTL and testbench

YSYX_23060124__AXI_RD_ARB -- requirements
Module: ysyx_23060124__axi_rd_arb

---
 rtl/ysyx_23060124_pkg.sv | 22 ++
 rtl/ysyx_23060124__rr_arb2.sv | 13 +
 rtl/ysyx_23060124__axi_rd_arb.sv | 176 +++++++++++++++++
 tb/tb_ysyx_23060124__axi_rd_arb.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060124_pkg.sv
// Shared definitions for the ysyx_23060124 read-path blocks: arbiter FSM
// encoding, AXI field constants and the burst-length consistency check.
package ysyx_23060124_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_arb_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // A beat is malformed if rlast disagrees with the beat index implied by arlen.
  function automatic logic burst_len_err(input logic       last,
                                         input logic [7:0] cnt,
                                         input logic [7:0] len);
    return last ? (cnt != len) : (cnt == len);
  endfunction

endpackage

// File: rtl/ysyx_23060124__rr_arb2.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module ysyx_23060124__rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_vld,
  output logic gnt_idx
);

  assign gnt_vld = req0 | req1;
  assign gnt_idx = (req0 && req1) ? ~last_grant : req1;

endmodule

// File: rtl/ysyx_23060124__axi_rd_arb.sv
// Two-master AXI read-channel arbiter (icache = s0, LSU = s1) with a single
// outstanding transaction and burst-length checking on the returned data.
module ysyx_23060124__axi_rd_arb
  import ysyx_23060124_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  rst_n_sync,

  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [3:0]            s0_arid,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic [3:0]            s0_rid,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,

  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [3:0]            s1_arid,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic [3:0]            s1_rid,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,

  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [3:0]            m_arid,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic [3:0]            m_rid,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,

  output logic                  proto_err
);

  rd_arb_state_e state, state_nxt;

  logic                  last_grant;
  logic                  gnt_q;
  logic                  gnt_vld;
  logic                  gnt_idx;
  logic [7:0]            beat_cnt;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [3:0]            ar_id_q;
  logic [7:0]            ar_len_q;
  logic [2:0]            ar_size_q;
  logic [1:0]            ar_burst_q;

  logic take_grant;
  logic ar_hs;
  logic r_sel_ready;
  logic r_hs;

  ysyx_23060124__rr_arb2 u_rr_arb2 (
    .req0       (s0_arvalid),
    .req1       (s1_arvalid),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx)
  );

  // Every handshake is qualified by reset so nothing can complete while held.
  assign take_grant  = rst_n_sync && (state == ST_IDLE) && gnt_vld;
  assign ar_hs       = rst_n_sync && (state == ST_ADDR) && m_arready;
  assign r_sel_ready = gnt_q ? s1_rready : s0_rready;
  assign r_hs        = rst_n_sync && (state == ST_DATA) && m_rvalid && r_sel_ready;

  always_ff @(posedge clock) begin
    if (!rst_n_sync) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    proto_err  = 1'b0;
    if (rst_n_sync) begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            s0_arready = ~gnt_idx;
            s1_arready = gnt_idx;
            state_nxt  = ST_ADDR;
          end
        end
        ST_ADDR: begin
          m_arvalid = 1'b1;
          if (m_arready) state_nxt = ST_DATA;
        end
        ST_DATA: begin
          m_rready  = r_sel_ready;
          s0_rvalid = m_rvalid && !gnt_q;
          s1_rvalid = m_rvalid && gnt_q;
          proto_err = r_hs && burst_len_err(m_rlast, beat_cnt, ar_len_q);
          if (r_hs && m_rlast) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n_sync) begin
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      beat_cnt   <= 8'd0;
      ar_addr_q  <= '0;
      ar_id_q    <= 4'd0;
      ar_len_q   <= 8'd0;
      ar_size_q  <= 3'd0;
      ar_burst_q <= 2'd0;
    end else begin
      if (take_grant) begin
        gnt_q      <= gnt_idx;
        ar_addr_q  <= gnt_idx ? s1_araddr  : s0_araddr;
        ar_id_q    <= gnt_idx ? s1_arid    : s0_arid;
        ar_len_q   <= gnt_idx ? s1_arlen   : s0_arlen;
        ar_size_q  <= gnt_idx ? s1_arsize  : s0_arsize;
        ar_burst_q <= gnt_idx ? s1_arburst : s0_arburst;
      end
      if (ar_hs) begin
        beat_cnt <= 8'd0;
      end else if (r_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      // Fairness history only moves once a burst has fully retired.
      if (r_hs && m_rlast) last_grant <= gnt_q;
    end
  end

  assign m_araddr  = ar_addr_q;
  assign m_arid    = ar_id_q;
  assign m_arlen   = ar_len_q;
  assign m_arsize  = ar_size_q;
  assign m_arburst = ar_burst_q;

  // Payload fans out to both requesters; only the rvalid steering selects.
  assign s0_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s0_rid   = m_rid;
  assign s0_rlast = m_rlast;
  assign s1_rdata = m_rdata;
  assign s1_rresp = m_rresp;
  assign s1_rid   = m_rid;
  assign s1_rlast = m_rlast;

endmodule

// File: tb/tb_ysyx_23060124__axi_rd_arb.sv
// Bench for the two-master AXI read arbiter: directed scenarios followed by
// randomized traffic scored against a transaction-level reference model.
module tb_ysyx_23060124__axi_rd_arb;
  import ysyx_23060124_pkg::*;

  logic        clock;
  logic        rst_n_sync;
  logic [31:0] s0_araddr, s1_araddr, m_araddr;
  logic [3:0]  s0_arid, s1_arid, m_arid;
  logic [7:0]  s0_arlen, s1_arlen, m_arlen;
  logic [2:0]  s0_arsize, s1_arsize, m_arsize;
  logic [1:0]  s0_arburst, s1_arburst, m_arburst;
  logic        s0_arvalid, s1_arvalid, m_arvalid;
  logic        s0_arready, s1_arready, m_arready;
  logic [31:0] s0_rdata, s1_rdata, m_rdata;
  logic [1:0]  s0_rresp, s1_rresp, m_rresp;
  logic [3:0]  s0_rid, s1_rid, m_rid;
  logic        s0_rlast, s1_rlast, m_rlast;
  logic        s0_rvalid, s1_rvalid, m_rvalid;
  logic        s0_rready, s1_rready, m_rready;
  logic        proto_err;

  ysyx_23060124__axi_rd_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock(clock), .rst_n_sync(rst_n_sync),
    .s0_araddr(s0_araddr), .s0_arid(s0_arid), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rid(s0_rid), .s0_rlast(s0_rlast),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arid(s1_arid), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rid(s1_rid), .s1_rlast(s1_rlast),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rid(m_rid), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .proto_err(proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Requester-side model: pending requests and their AR payloads.
  logic        pend   [2];
  logic [31:0] r_addr [2];
  logic [3:0]  r_id   [2];
  logic [7:0]  r_len  [2];
  logic [2:0]  r_size [2];
  logic [1:0]  r_burst[2];
  int          pref;   // requester that wins when both ask at once

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {s0_arready, s1_arready, s0_rvalid, s1_rvalid, m_arvalid, m_rready, proto_err}, 0);
  endtask

  task automatic new_req(input int i);
    pend[i]    = 1'b1;
    r_addr[i]  = $urandom;
    r_id[i]    = 4'($urandom_range(15, 0));
    r_len[i]   = 8'($urandom_range(7, 0));
    r_size[i]  = 3'($urandom_range(7, 0));
    r_burst[i] = 2'($urandom_range(3, 0));
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    pend[i] = 1'b1; r_addr[i] = a; r_id[i] = id; r_len[i] = len;
    r_size[i] = SIZE_4B; r_burst[i] = BURST_INCR;
  endtask

  task automatic drive_ar();
    s0_arvalid = pend[0]; s0_araddr = r_addr[0]; s0_arid = r_id[0];
    s0_arlen = r_len[0]; s0_arsize = r_size[0]; s0_arburst = r_burst[0];
    s1_arvalid = pend[1]; s1_araddr = r_addr[1]; s1_arid = r_id[1];
    s1_arlen = r_len[1]; s1_arsize = r_size[1]; s1_arburst = r_burst[1];
  endtask

  // Requests come and go while the arbiter is busy; withdrawn ones must vanish.
  task automatic background(input bit en);
    if (en) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(7, 0) == 0) new_req(i);
        else if (pend[i] && $urandom_range(15, 0) == 0) pend[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    rst_n_sync = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0; drive_ar();
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    @(negedge clock); chk_quiet("rst_outputs_a");
    @(posedge clock); #1;
    @(negedge clock); chk_quiet("rst_outputs_b");
    chk("rst_state", dut.state, ST_IDLE);
    @(posedge clock); #1;
    rst_n_sync = 1'b1;
    pref = 0;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clock); #1;
    s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_rvalid = 1'b0; m_arready = 1'b0;
    @(negedge clock);
    chk(tag, dut.state, ST_IDLE);
    chk_quiet({tag, "_quiet"});
  endtask

  // One complete transaction: arbitration, address phase, data phase.
  // lastbeat: -1 = well-formed burst, -2 = random rlast position, else exact index.
  task automatic do_txn(input bit rand_bg, input bit ar_rand, input int hold,
                        input int lastbeat, input bit rv_rand, output int errs);
    int win, cyc, beats, lb;
    bit done, rr, hs, eerr;
    logic [31:0] e_addr; logic [3:0] e_id; logic [7:0] e_len;
    logic [2:0] e_size; logic [1:0] e_burst;
    errs = 0;
    win = -1; cyc = 0;
    while (win < 0 && cyc < 50) begin
      @(posedge clock); #1;
      if (rand_bg) begin
        for (int i = 0; i < 2; i++) if (!pend[i] && $urandom_range(2, 0) == 0) new_req(i);
      end
      drive_ar();
      m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
      s0_rready = 1'($urandom_range(1, 0)); s1_rready = 1'($urandom_range(1, 0));
      @(negedge clock);
      if (!pend[0] && !pend[1]) win = -1;
      else if (pend[0] && pend[1]) win = pref;
      else win = pend[0] ? 0 : 1;
      chk("s0_arready", s0_arready, win == 0);
      chk("s1_arready", s1_arready, win == 1);
      chk("idle_quiet", {m_arvalid, m_rready, s0_rvalid, s1_rvalid}, 0);
      cyc++;
    end
    if (win < 0) begin
      chk("grant_timeout", 0, 1);
      return;
    end
    e_addr = r_addr[win]; e_id = r_id[win]; e_len = r_len[win];
    e_size = r_size[win]; e_burst = r_burst[win];
    pend[win] = 1'b0;

    done = 0; cyc = 0;
    while (!done && cyc < 50) begin
      @(posedge clock); #1;
      background(rand_bg); drive_ar();
      m_arready = ar_rand ? ($urandom_range(2, 0) == 0) : 1'b1;
      m_rvalid = 1'b0;
      @(negedge clock);
      chk("m_arvalid", m_arvalid, 1);
      chk("m_ar_payload", {m_araddr, m_arid, m_arlen, m_arsize, m_arburst},
          {e_addr, e_id, e_len, e_size, e_burst});
      chk("addr_quiet", {m_rready, s0_arready, s1_arready, s0_rvalid, s1_rvalid}, 0);
      done = m_arready; cyc++;
    end
    if (!done) begin
      chk("addr_timeout", 0, 1);
      return;
    end

    if (lastbeat == -1) lb = int'(e_len);
    else if (lastbeat == -2) lb = $urandom_range(int'(e_len) + 2, 0);
    else lb = lastbeat;
    beats = 0; done = 0; cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clock); #1;
      background(rand_bg); drive_ar();
      m_arready = 1'b0;
      m_rvalid = (cyc < hold) ? 1'b1 : (rv_rand ? ($urandom_range(3, 0) != 0) : 1'b1);
      m_rdata = $urandom; m_rid = 4'($urandom_range(15, 0));
      m_rresp = 2'($urandom_range(3, 0)); m_rlast = (beats == lb);
      rr = (cyc < hold) ? 1'b0 : (rv_rand ? ($urandom_range(2, 0) != 0) : 1'b1);
      s0_rready = (win == 0) ? rr : 1'($urandom_range(1, 0));
      s1_rready = (win == 1) ? rr : 1'($urandom_range(1, 0));
      @(negedge clock);
      hs = m_rvalid && rr;
      eerr = hs && ((m_rlast && beats != int'(e_len)) || (!m_rlast && beats == int'(e_len)));
      chk("data_ar_quiet", {m_arvalid, s0_arready, s1_arready}, 0);
      chk("m_rready", m_rready, rr);
      chk("proto_err", proto_err, eerr);
      chk("win_rvalid", (win == 0) ? s0_rvalid : s1_rvalid, m_rvalid);
      chk("other_rvalid", (win == 0) ? s1_rvalid : s0_rvalid, 0);
      if (m_rvalid) begin
        if (win == 0) chk("s0_r_payload", {s0_rdata, s0_rid, s0_rresp, s0_rlast},
                          {m_rdata, m_rid, m_rresp, m_rlast});
        else          chk("s1_r_payload", {s1_rdata, s1_rid, s1_rresp, s1_rlast},
                          {m_rdata, m_rid, m_rresp, m_rlast});
      end
      if (proto_err) errs++;
      if (hs) begin
        beats++;
        if (m_rlast) done = 1;
      end
      cyc++;
    end
    if (!done) chk("data_timeout", 0, 1);
    pref = 1 - win;
  endtask

  initial begin
    int errs, hold, lbm;
    rst_n_sync = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    m_rdata = '0; m_rid = '0; m_rresp = RESP_OKAY; s0_rready = 1'b0; s1_rready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; r_addr[i] = '0; r_id[i] = '0; r_len[i] = '0;
      r_size[i] = '0; r_burst[i] = '0;
    end
    drive_ar();
    pref = 0;

    // Single 8-beat icache burst
    do_reset();
    set_req(0, 32'h8000_0020, 4'h5, 8'd7); pend[1] = 1'b0;
    do_txn(0, 0, 0, -1, 0, errs);
    chk("r31_no_err", errs, 0);
    idle_check("r31_idle");

    // LSU single beat with requester back-pressure
    set_req(1, 32'h8000_1004, 4'hA, 8'd0);
    do_txn(0, 0, 3, -1, 0, errs);
    idle_check("r33_idle");

    // Early rlast on an 8-beat burst
    set_req(0, 32'h8000_0040, 4'h2, 8'd7);
    do_txn(0, 0, 0, 3, 0, errs);
    chk("r34_err_pulses", errs, 1);
    idle_check("r34_idle");

    // Reset landing on beat 3 of a burst
    do_reset();
    set_req(0, 32'h8000_1000, 4'h1, 8'd7); pend[1] = 1'b0;
    @(posedge clock); #1; drive_ar();
    @(negedge clock); chk("r35_grant_s0", {s0_arready, s1_arready}, 2'b10);
    pend[0] = 1'b0;
    @(posedge clock); #1; drive_ar(); m_arready = 1'b1;
    @(negedge clock); chk("r35_arvalid", m_arvalid, 1);
    for (int b = 0; b < 2; b++) begin
      @(posedge clock); #1;
      m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = $urandom; s0_rready = 1'b1;
      @(negedge clock); chk("r35_beat", {s0_rvalid, s0_rdata}, {1'b1, m_rdata});
    end
    @(posedge clock); #1; rst_n_sync = 1'b0;
    @(negedge clock); chk_quiet("r35_in_reset");
    @(posedge clock); #1; rst_n_sync = 1'b1;
    @(negedge clock);
    chk_quiet("r35_after_reset");
    chk("r35_state", dut.state, ST_IDLE);
    pref = 0;
    set_req(1, 32'h8000_2000, 4'h7, 8'd1);
    do_txn(0, 0, 0, -1, 0, errs);

    // Simultaneous requests straight after reset
    do_reset();
    set_req(0, 32'h8000_3000, 4'h3, 8'd3);
    set_req(1, 32'h8000_4000, 4'h4, 8'd2);
    do_txn(0, 0, 0, -1, 0, errs);
    do_txn(0, 0, 0, -1, 0, errs);
    idle_check("r32_idle");

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(14, 0) == 0) do_reset();
      hold = ($urandom_range(3, 0) == 0) ? $urandom_range(2, 0) : 0;
      lbm  = ($urandom_range(4, 0) == 0) ? -2 : -1;
      do_txn(1, 1, hold, lbm, 1, errs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
